time_scale_ctrl: RTL and testbench

TIME_SCALE_CTRL -- requirements
Module: time_scale_ctrl

---
 rtl/time_scale_ctrl.sv | 144 ++++++++++++++
 tb/tb_time_scale_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/time_scale_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_scale_ctrl
// Description : Debounced up/down buttons select a 1-2-5 time-scale index and
//               drive a sample strobe at the matching divide ratio.
// Revision    : 1.0 - initial release
// ============================================================================
module time_scale_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCALE_MAX       = 18,
    parameter int SCALE_INIT      = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [4:0] scale_out,
    output logic       sample_en,
    output logic       scale_changed
);

    localparam int              c_DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]      c_SCALE_MAX = 5'(SCALE_MAX);
    localparam logic [4:0]      c_SCALE_INIT = 5'(SCALE_INIT);

    // Divide ratio minus one, so the counter compare needs no subtractor.
    function automatic logic [19:0] div_m1(input logic [4:0] s);
        case (s)
            5'd0:    div_m1 = 20'd0;
            5'd1:    div_m1 = 20'd1;
            5'd2:    div_m1 = 20'd4;
            5'd3:    div_m1 = 20'd9;
            5'd4:    div_m1 = 20'd19;
            5'd5:    div_m1 = 20'd49;
            5'd6:    div_m1 = 20'd99;
            5'd7:    div_m1 = 20'd199;
            5'd8:    div_m1 = 20'd499;
            5'd9:    div_m1 = 20'd999;
            5'd10:   div_m1 = 20'd1999;
            5'd11:   div_m1 = 20'd4999;
            5'd12:   div_m1 = 20'd9999;
            5'd13:   div_m1 = 20'd19999;
            5'd14:   div_m1 = 20'd49999;
            5'd15:   div_m1 = 20'd99999;
            5'd16:   div_m1 = 20'd199999;
            5'd17:   div_m1 = 20'd499999;
            default: div_m1 = 20'd999999;
        endcase
    endfunction

    logic [1:0]  w_btn_raw;
    logic [1:0]  w_deb;
    logic [1:0]  r_deb_d;
    logic        w_up_evt;
    logic        w_dn_evt;
    logic [4:0]  w_scale_nxt;
    logic        w_change;
    logic [19:0] w_div_nxt;
    logic [19:0] w_cnt_nxt;
    logic [4:0]  r_scale;
    logic        r_changed;
    logic        r_sample;
    logic [19:0] r_div_m1;
    logic [19:0] r_cnt;

    assign w_btn_raw = {btn_down, btn_up};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic              r_sync1;
            logic              r_sync2;
            logic              r_deb;
            logic [c_DB_W-1:0] r_cnt_db;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1  <= 1'b0;
                    r_sync2  <= 1'b0;
                    r_deb    <= 1'b0;
                    r_cnt_db <= '0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_deb) begin
                        r_cnt_db <= '0;
                    end else if (r_cnt_db == c_DB_LAST) begin
                        r_deb    <= r_sync2;
                        r_cnt_db <= '0;
                    end else begin
                        r_cnt_db <= r_cnt_db + 1'b1;
                    end
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    // Press = rising edge of the debounced level; releases and holds are ignored.
    assign w_up_evt = w_deb[0] & ~r_deb_d[0];
    assign w_dn_evt = w_deb[1] & ~r_deb_d[1];

    always_comb begin
        w_scale_nxt = r_scale;
        w_change    = 1'b0;
        if (w_up_evt && !w_dn_evt && (r_scale < c_SCALE_MAX)) begin
            w_scale_nxt = r_scale + 5'd1;
            w_change    = 1'b1;
        end else if (w_dn_evt && !w_up_evt && (r_scale != 5'd0)) begin
            w_scale_nxt = r_scale - 5'd1;
            w_change    = 1'b1;
        end
    end

    // Lookup follows the next scale so the restarted count never sees a stale ratio.
    assign w_div_nxt = div_m1(w_scale_nxt);
    assign w_cnt_nxt = w_change               ? 20'd0 :
                       (r_cnt == r_div_m1)    ? 20'd0 : r_cnt + 20'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_d   <= 2'b00;
            r_scale   <= c_SCALE_INIT;
            r_changed <= 1'b0;
            r_div_m1  <= div_m1(c_SCALE_INIT);
            r_cnt     <= 20'd0;
            r_sample  <= 1'b0;
        end else begin
            r_deb_d   <= w_deb;
            r_scale   <= w_scale_nxt;
            r_changed <= w_change;
            r_div_m1  <= w_div_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sample  <= (w_cnt_nxt == w_div_nxt);
        end
    end

    assign scale_out     = r_scale;
    assign scale_changed = r_changed;
    assign sample_en     = r_sample;

endmodule
`default_nettype wire

// File: tb/tb_time_scale_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_scale_ctrl
// Description : Scoreboard bench for time_scale_ctrl with directed button vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_scale_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic [4:0] scale_out;
    logic       sample_en;
    logic       scale_changed;

    typedef struct {
        int cyc;
        int scale;
    } chg_t;

    chg_t chg_q[$];
    int   se_q[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   track_se;

    time_scale_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SCALE_MAX      (18),
        .SCALE_INIT     (9)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .scale_out    (scale_out),
        .sample_en    (sample_en),
        .scale_changed(scale_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every scale_changed / tracked sample_en pops an expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (scale_changed) begin
                if (chg_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected scale_changed: got pulse at cycle %0d scale %0d, expected none",
                             cyc, scale_out);
                end else begin
                    chg_t e;
                    e = chg_q.pop_front();
                    check("chg_cycle", cyc, e.cyc);
                    check("chg_scale", int'(scale_out), e.scale);
                end
            end
            if (track_se && sample_en) begin
                if (se_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected sample_en: got strobe at cycle %0d, expected none", cyc);
                end else begin
                    check("strobe_cycle", cyc, se_q.pop_front());
                end
            end
        end
    end

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // One press: hold 10 cycles, release 10 cycles; change lands 2+4+1 edges after the rise.
    task automatic press(input bit up, input bit dn, input bit exp_chg, input int new_scale);
        int   t0;
        chg_t e;
        t0 = cyc;
        btn_up   = up;
        btn_down = dn;
        if (exp_chg) begin
            e.cyc   = t0 + 7;
            e.scale = new_scale;
            chg_q.push_back(e);
        end
        to_cyc(t0 + 10);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        to_cyc(t0 + 20);
    endtask

    initial begin
        int   t0;
        chg_t e;
        n_cmp    = 0;
        n_bad    = 0;
        track_se = 1'b0;
        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scale", int'(scale_out), 9);
        check("rst_sample_en", int'(sample_en), 0);
        check("rst_scale_changed", int'(scale_changed), 0);

        // Idle at scale 9: strobes at 999, 1999, 2999; 3-cycle glitch ignored.
        rst_n    = 1'b1;
        track_se = 1'b1;
        se_q.push_back(999);
        se_q.push_back(1999);
        se_q.push_back(2999);
        se_q.push_back(5006);
        se_q.push_back(7006);
        to_cyc(100);
        btn_up = 1'b1;
        to_cyc(103);
        btn_up = 1'b0;
        to_cyc(200);
        check("glitch_scale", int'(scale_out), 9);

        // Up press at 3000 -> scale 10 at 3007, then strobes every 2000.
        to_cyc(3000);
        press(1'b1, 1'b0, 1'b1, 10);
        to_cyc(7010);
        track_se = 1'b0;
        check("scale_after_up", int'(scale_out), 10);

        for (int s = 11; s <= 18; s++) press(1'b1, 1'b0, 1'b1, s);
        press(1'b1, 1'b0, 1'b0, 0);
        check("hold_at_max", int'(scale_out), 18);

        for (int s = 17; s >= 0; s--) press(1'b0, 1'b1, 1'b1, s);
        press(1'b0, 1'b1, 1'b0, 0);
        check("hold_at_zero", int'(scale_out), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("d1_sample_en", int'(sample_en), 1);
        end

        press(1'b1, 1'b0, 1'b1, 1);
        press(1'b1, 1'b0, 1'b1, 2);
        press(1'b1, 1'b1, 1'b0, 0);
        check("simultaneous_hold", int'(scale_out), 2);

        // 2 -> 1 mid-count: strobe one cycle after the change, period 2.
        t0 = cyc;
        btn_down = 1'b1;
        e.cyc   = t0 + 7;
        e.scale = 1;
        chg_q.push_back(e);
        to_cyc(t0 + 7);
        check("no_stale_strobe", int'(sample_en), 0);
        se_q.push_back(t0 + 8);
        se_q.push_back(t0 + 10);
        se_q.push_back(t0 + 12);
        se_q.push_back(t0 + 14);
        track_se = 1'b1;
        to_cyc(t0 + 10);
        btn_down = 1'b0;
        to_cyc(t0 + 15);
        track_se = 1'b0;
        to_cyc(t0 + 20);
        check("scale_after_down", int'(scale_out), 1);

        // Reset mid-debounce with btn_down held through release.
        t0 = cyc;
        btn_down = 1'b1;
        to_cyc(t0 + 4);
        rst_n = 1'b0;
        #1;
        check("async_rst_scale", int'(scale_out), 9);
        check("async_rst_sample_en", int'(sample_en), 0);
        check("async_rst_changed", int'(scale_changed), 0);
        repeat (3) @(negedge clk);
        e.cyc   = 7;
        e.scale = 8;
        chg_q.push_back(e);
        rst_n = 1'b1;
        to_cyc(20);
        btn_down = 1'b0;
        to_cyc(40);
        check("scale_after_reset_press", int'(scale_out), 8);

        while (chg_q.size() > 0) begin
            e = chg_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing scale_changed: got none, expected cycle %0d scale %0d", e.cyc, e.scale);
        end
        while (se_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing sample_en: got none, expected cycle %0d", se_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
